// File: rtl/ex_bus_bridge.sv
// Core data-bus to split grant/response slave bridge with per-access timeout.
// Optional timeout address capture: define EX_BUS_BRIDGE_ERR_CAPTURE_EN.
module ex_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_data_i,
    input  logic        core_we_i,
    input  logic        core_req_i,
    output logic [31:0] core_data_o,
    output logic        core_ack_o,
    output logic        hold_flag_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
`ifdef EX_BUS_BRIDGE_ERR_CAPTURE_EN
    input  logic        err_clr_i,
    output logic [31:0] err_addr_o,
    output logic        err_we_o,
`endif
    output logic        err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Last counter value of the window: the access spends exactly TIMEOUT_CYCLES cycles in REQ+RSP.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              timeout_hit;
    logic              timeout_fire;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Completion is tested before the timeout so a response on the last cycle still succeeds.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        timeout_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    addr_d  = core_addr_i;
                    wdata_d = core_data_i;
                    we_d    = core_we_i;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (s_gnt_i && (we_q || s_rvalid_i)) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = s_rdata_i;
                end else if (timeout_hit) begin
                    state_d      = DONE;
                    err_d        = 1'b1;
                    timeout_fire = 1'b1;
                    if (!we_q) rdata_d = ERR_DATA;
                end else if (s_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                cnt_d = cnt_q + 1'b1;
                if (s_rvalid_i) begin
                    state_d = DONE;
                    rdata_d = s_rdata_i;
                end else if (timeout_hit) begin
                    state_d      = DONE;
                    err_d        = 1'b1;
                    timeout_fire = 1'b1;
                    rdata_d      = ERR_DATA;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_req_o     = (state_q == REQ);
        s_we_o      = we_q;
        s_addr_o    = addr_q;
        s_wdata_o   = wdata_q;
        core_ack_o  = (state_q == DONE);
        core_data_o = rdata_q;
        err_o       = err_q;
        hold_flag_o = ((state_q == IDLE) && core_req_i) || (state_q == REQ) || (state_q == RSP);
    end

`ifdef EX_BUS_BRIDGE_ERR_CAPTURE_EN
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_we_q, err_we_d;

    // A timeout in the same cycle as a clear request keeps the new capture.
    always_comb begin
        err_addr_d = err_addr_q;
        err_we_d   = err_we_q;
        if (timeout_fire) begin
            err_addr_d = addr_q;
            err_we_d   = we_q;
        end else if (err_clr_i) begin
            err_addr_d = '0;
            err_we_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_addr_q <= '0;
            err_we_q   <= 1'b0;
        end else begin
            err_addr_q <= err_addr_d;
            err_we_q   <= err_we_d;
        end
    end

    assign err_addr_o = err_addr_q;
    assign err_we_o   = err_we_q;
`endif

endmodule
